// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and the receiver state encoding.
// The transmitter will reuse these, so keep them generic.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver output bundle: one word per frame plus its error flags and busy.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx_data, rx_valid, parity_err, frame_err, busy);
    modport slave  (input  rx_data, rx_valid, parity_err, frame_err, busy);

endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the rx pin plus a 3-tap majority vote.
// taps hold the two earlier samples; the third vote is the live rx_s.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic sample,
    output logic rx_s,
    output logic bit_val
);

    logic       meta;
    logic [1:0] taps;

    // Idle-high reset so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            taps <= 2'b11;
        end else begin
            meta <= rx;
            rx_s <= meta;
            if (sample) begin
                taps <= {taps[0], rx_s};
            end
        end
    end

    assign bit_val = (taps[1] & taps[0]) | (taps[1] & rx_s) | (taps[0] & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS payload, optional parity, 1/2 stop bits,
// majority-voted mid-bit sampling, false-start rejection and break handling.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_cfg_if.master rx_bus
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_chk_cpb
        $error("uart_rx_cfg: CLKS_PER_BIT must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_chk_par
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 rx_s;
    logic                 bit_val;
    logic                 sample;
    logic                 decide;
    logic                 exp_par;

    assign sample  = (state != ST_IDLE) && ((cnt == CNT_S0) || (cnt == CNT_S1));
    assign decide  = (cnt == CNT_DEC);
    assign exp_par = (^shreg) ^ (PARITY == PAR_ODD);
    assign rx_bus.busy = (state != ST_IDLE);

    uart_rx_sampler u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .sample  (sample),
        .rx_s    (rx_s),
        .bit_val (bit_val)
    );

    // The counter free-runs through the frame; states change only at the
    // decision count, so each state spans from one bit centre to the next.
    // A start is ignored during the strobe cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            idx               <= '0;
            shreg             <= '0;
            par_err_q         <= 1'b0;
            frm_err_q         <= 1'b0;
            rx_bus.rx_data    <= '0;
            rx_bus.rx_valid   <= 1'b0;
            rx_bus.parity_err <= 1'b0;
            rx_bus.frame_err  <= 1'b0;
        end else begin
            rx_bus.rx_valid <= 1'b0;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s && !rx_bus.rx_valid) begin
                        state     <= ST_START;
                        cnt       <= CW'(1);
                        idx       <= '0;
                        shreg     <= '0;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (idx == LAST_DATA) begin
                            idx   <= '0;
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        if (bit_val != exp_par) begin
                            par_err_q <= 1'b1;
                        end
                        idx   <= '0;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        if (idx == LAST_STOP) begin
                            rx_bus.rx_valid   <= 1'b1;
                            rx_bus.rx_data    <= shreg;
                            rx_bus.parity_err <= par_err_q;
                            rx_bus.frame_err  <= frm_err_q | ~bit_val;
                            state <= (frm_err_q | ~bit_val) ? ST_BREAK : ST_IDLE;
                        end else begin
                            frm_err_q <= frm_err_q | ~bit_val;
                            idx       <= idx + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Four receiver lanes (8N1, 7E1, 7O1, 8N2) on one clock; frames are built from
// bit lists, the expected word is queued, and a monitor pops it on each strobe.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPB = 16;

    typedef struct {
        int         lane;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         exp_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rx_line = 4'hF;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sb_q[$];
    logic [8:0] last_data [4];

    uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) bus1 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) bus2 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) bus3 ();

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .rx(rx_line[0]), .rx_bus(bus0));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1))
        dut1 (.clk(clk), .rst(rst), .rx(rx_line[1]), .rx_bus(bus1));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(1))
        dut2 (.clk(clk), .rst(rst), .rx(rx_line[2]), .rx_bus(bus2));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2))
        dut3 (.clk(clk), .rst(rst), .rx(rx_line[3]), .rx_bus(bus3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int laneDb(input int l);
        return (l == 1 || l == 2) ? 7 : 8;
    endfunction

    function automatic int lanePar(input int l);
        return (l == 1) ? 2 : ((l == 2) ? 1 : 0);
    endfunction

    function automatic int laneStop(input int l);
        return (l == 3) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic popAndCheck(input int lane, input logic [8:0] data,
                               input logic perr, input logic ferr);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_strobe: lane %0d gave data 0x%0h, required no strobe at cycle %0d",
                     lane, data, cyc);
            return;
        end
        e = sb_q.pop_front();
        checkOutput("strobe_lane", lane, e.lane);
        checkOutput("rx_data", int'(data), int'(e.data));
        checkOutput("parity_err", int'(perr), int'(e.perr));
        checkOutput("frame_err", int'(ferr), int'(e.ferr));
        if (e.exp_cyc >= 0) begin
            checkOutput("strobe_latency", cyc, e.exp_cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, well away from the register updates.
    always @(negedge clk) begin
        if (bus0.rx_valid) popAndCheck(0, 9'(bus0.rx_data), bus0.parity_err, bus0.frame_err);
        if (bus1.rx_valid) popAndCheck(1, 9'(bus1.rx_data), bus1.parity_err, bus1.frame_err);
        if (bus2.rx_valid) popAndCheck(2, 9'(bus2.rx_data), bus2.parity_err, bus2.frame_err);
        if (bus3.rx_valid) popAndCheck(3, 9'(bus3.rx_data), bus3.parity_err, bus3.frame_err);
    end

    task automatic idle(input int lane, input int n);
        repeat (n) begin
            @(negedge clk);
            rx_line[lane] = 1'b1;
        end
    endtask

    // One frame on one lane; the expected result comes from the wire bits.
    task automatic applyStimulus(input int lane, input logic [8:0] word, input bit flip_par,
                                 input logic [1:0] stop_low, input bit glitch, input bit check_lat);
        int         db, par, sb, n, ones, k, s, c;
        logic       pbit, v;
        logic       bits[$];
        logic [8:0] w;
        exp_t       e;
        db   = laneDb(lane);
        par  = lanePar(lane);
        sb   = laneStop(lane);
        w    = word & ((9'h1 << db) - 9'h1);
        ones = $countones(w);
        pbit = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(w[i]);
        if (par != 0) begin
            pbit = ((ones % 2) == 1) ^ (par == 1) ^ flip_par;
            bits.push_back(pbit);
        end
        e.ferr = 1'b0;
        for (int i = 0; i < sb; i++) begin
            bits.push_back(~stop_low[i]);
            e.ferr = e.ferr | stop_low[i];
        end
        e.lane = lane;
        e.data = w;
        e.perr = (par != 0) && (((ones + int'(pbit)) % 2) != ((par == 1) ? 1 : 0));
        n = bits.size();
        @(negedge clk);
        k = cyc;
        e.exp_cyc = check_lat ? (k + (n - 1) * CPB + CPB / 2 + 4) : -1;
        sb_q.push_back(e);
        last_data[lane] = w;
        for (int t = 0; t < n * CPB; t++) begin
            if (t > 0) @(negedge clk);
            s = t / CPB;
            c = t % CPB;
            v = bits[s];
            if (glitch && s >= 1 && s <= db && c == CPB / 2) v = ~v;
            rx_line[lane] = v;
        end
    endtask

    // Back-to-back 8N1 frames on lane 0 at 3% fast baud (15.52 clocks per bit).
    task automatic applyStream(input int nw);
        logic       bits[$];
        logic [8:0] w;
        exp_t       e;
        int         slot;
        for (int i = 0; i < nw; i++) begin
            w = 9'($urandom_range(0, 255));
            bits.push_back(1'b0);
            for (int b = 0; b < 8; b++) bits.push_back(w[b]);
            bits.push_back(1'b1);
            e.lane = 0; e.data = w; e.perr = 1'b0; e.ferr = 1'b0; e.exp_cyc = -1;
            sb_q.push_back(e);
            last_data[0] = w;
        end
        for (int t = 0; ; t++) begin
            slot = (t * 25) / 388;
            if (slot >= bits.size()) break;
            @(negedge clk);
            rx_line[0] = bits[slot];
        end
        idle(0, 4);
    endtask

    task automatic falseStart(input int width);
        int k;
        @(negedge clk);
        k = cyc;
        rx_line[0] = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            if (t == width) rx_line[0] = 1'b1;
            if (cyc == k + 11) checkOutput("false_start_busy_at_decision", int'(bus0.busy), 1);
            if (cyc == k + 12) begin
                checkOutput("false_start_busy_after", int'(bus0.busy), 0);
                checkOutput("false_start_data_held", int'(9'(bus0.rx_data)), int'(last_data[0]));
            end
        end
        idle(0, 4);
    endtask

    task automatic resetMidFrame(input logic [7:0] word);
        logic bits[$];
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(word[b]);
        @(negedge clk);
        for (int t = 0; t < 5 * CPB + 4; t++) begin
            if (t > 0) @(negedge clk);
            rx_line[0] = bits[t / CPB];
        end
        @(negedge clk);
        rst = 1'b1;
        rx_line[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int l = 0; l < 4; l++) last_data[l] = 9'h0;
        checkOutput("mid_reset_rx_data", int'(9'(bus0.rx_data)), 0);
        checkOutput("mid_reset_busy", int'(bus0.busy), 0);
        checkOutput("mid_reset_valid", int'(bus0.rx_valid), 0);
        idle(0, 2 * CPB);
    endtask

    initial begin
        int         lane, db, budget;
        logic [1:0] sl;
        for (int l = 0; l < 4; l++) last_data[l] = 9'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data0", int'(9'(bus0.rx_data)), 0);
        checkOutput("reset_valid0", int'(bus0.rx_valid), 0);
        checkOutput("reset_busy0", int'(bus0.busy), 0);
        checkOutput("reset_perr1", int'(bus1.parity_err), 0);
        checkOutput("reset_ferr3", int'(bus3.frame_err), 0);
        checkOutput("reset_busy3", int'(bus3.busy), 0);
        rst = 1'b0;
        idle(0, 5);

        $display("[TB] 8N1 word with latency check");
        applyStimulus(0, 9'h0A5, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(0, 4);

        $display("[TB] 7E1 and 7O1 parity");
        applyStimulus(1, 9'h041, 1'b0, 2'b00, 1'b0, 1'b0); idle(1, 4);
        applyStimulus(1, 9'h041, 1'b1, 2'b00, 1'b0, 1'b0); idle(1, 4);
        applyStimulus(2, 9'h041, 1'b0, 2'b00, 1'b0, 1'b0); idle(2, 4);
        applyStimulus(2, 9'h041, 1'b1, 2'b00, 1'b0, 1'b0); idle(2, 4);

        $display("[TB] false starts");
        falseStart(1);
        falseStart(3);

        $display("[TB] framing error and held break");
        applyStimulus(3, 9'h096, 1'b0, 2'b10, 1'b0, 1'b0);
        repeat (100 * CPB) begin
            @(negedge clk);
            rx_line[3] = 1'b0;
        end
        checkOutput("break_busy", int'(bus3.busy), 1);
        idle(3, 20);
        applyStimulus(3, 9'h03C, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(3, 4);

        $display("[TB] glitch rejection and fast back-to-back frames");
        applyStimulus(0, 9'h000, 1'b0, 2'b00, 1'b1, 1'b1);
        idle(0, 4);
        applyStream(6);

        $display("[TB] reset during data bit 4");
        resetMidFrame(8'hC3);
        applyStimulus(0, 9'h05A, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(0, 4);

        $display("[TB] randomized frames");
        for (int i = 0; i < 40; i++) begin
            lane = $urandom_range(0, 3);
            db   = laneDb(lane);
            sl   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (laneStop(lane) == 1) sl[1] = 1'b0;
            applyStimulus(lane, 9'($urandom_range(0, (1 << db) - 1)),
                          ($urandom_range(0, 3) == 0), sl, ($urandom_range(0, 1) == 1),
                          1'b1);
            idle(lane, $urandom_range(3, 30));
        end

        budget = 0;
        while (sb_q.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
